// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the 32x32 register file's single write port.
// Arbitrates load returns, ALU results and debug writes, and tracks pending loads for the hazard stall.
module regfile_wb_sched #(
    parameter int LD_FIFO_DEPTH = 2,
    parameter int DBG_MAX_WAIT  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        dbg_valid,
    input  logic [4:0]  dbg_rd,
    input  logic [31:0] dbg_data,
    output logic        dbg_ready,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_rd,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    input  logic [4:0]  chk_rd,
    output logic        hazard,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] busy_vec
);

    localparam int AW = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
    localparam int WW = $clog2(DBG_MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(DBG_MAX_WAIT);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(LD_FIFO_DEPTH);

    logic [4:0]    fifo_rd_q   [LD_FIFO_DEPTH];
    logic [31:0]   fifo_data_q [LD_FIFO_DEPTH];
    logic [AW-1:0] rptr_q, wptr_q;
    logic [AW:0]   cnt_q;
    logic          fifo_empty, fifo_full, push, pop;

    logic [WW-1:0] dbg_wait_q, dbg_wait_d;
    logic [31:0]   busy_q, busy_d;
    logic          wb_en_q;
    logic [4:0]    wb_rd_q;
    logic [31:0]   wb_data_q;

    logic          dbg_force, gnt_fifo, gnt_alu, gnt_dbg, any_gnt;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FIFO_FULL);
    assign push       = ld_valid && !fifo_full;
    assign pop        = gnt_fifo;

    // A starved debug request preempts everything, including the load FIFO head.
    assign dbg_force  = dbg_valid && (dbg_wait_q == WAIT_MAX);
    assign gnt_fifo   = !dbg_force && !fifo_empty;
    assign gnt_alu    = !dbg_force && fifo_empty && alu_valid;
    assign gnt_dbg    = dbg_valid && (dbg_force || (fifo_empty && !alu_valid));
    assign any_gnt    = gnt_fifo || gnt_alu || gnt_dbg;

    assign alu_ready  = gnt_alu;
    assign dbg_ready  = gnt_dbg;
    assign ld_ready   = !fifo_full;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        if (gnt_fifo) begin
            sel_rd   = fifo_rd_q[rptr_q];
            sel_data = fifo_data_q[rptr_q];
        end else if (gnt_alu) begin
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end else if (gnt_dbg) begin
            sel_rd   = dbg_rd;
            sel_data = dbg_data;
        end
    end

    always_comb begin
        dbg_wait_d = '0;
        if (dbg_valid && !gnt_dbg) begin
            dbg_wait_d = (dbg_wait_q == WAIT_MAX) ? WAIT_MAX : dbg_wait_q + 1'b1;
        end
    end

    // A new load to the same register outranks the return clearing it.
    always_comb begin
        busy_d = busy_q;
        if (gnt_fifo) begin
            busy_d[fifo_rd_q[rptr_q]] = 1'b0;
        end
        if (ld_issue) begin
            busy_d[ld_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wptr_q]   <= ld_rd;
            fifo_data_q[wptr_q] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            cnt_q      <= '0;
            dbg_wait_q <= '0;
            busy_q     <= '0;
            wb_en_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            dbg_wait_q <= dbg_wait_d;
            busy_q     <= busy_d;
            wb_en_q    <= any_gnt && (sel_rd != 5'd0);
            if (any_gnt) begin
                wb_rd_q   <= sel_rd;
                wb_data_q <= sel_data;
            end
        end
    end

    assign hazard = ((chk_rs1 != 5'd0) && busy_q[chk_rs1]) ||
                    ((chk_rs2 != 5'd0) && busy_q[chk_rs2]) ||
                    ((chk_rd  != 5'd0) && busy_q[chk_rd]);

    assign wb_en    = wb_en_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign busy_vec = busy_q;

endmodule
